wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath and register-data width.
REQ-002 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 stall  in  1  hold the MEM/WB register contents.
REQ-006 flush  in  1  load a bubble into the MEM/WB register.
REQ-007 VALID_MEM  in  1  MEM stage holds a real instruction.
REQ-008 RegWrite_MEM, MemtoReg_MEM  in  1 each  control bits from MEM.
REQ-009 ALU_RESULT_MEM  in  DATA_W  ALU result or load address.
REQ-010 MEM_DATA_MEM  in  DATA_W  raw aligned data-memory word.
REQ-011 FUNCT3_MEM  in  3  load size and sign selector.
REQ-012 RD_MEM  in  5  destination register.
REQ-013 RegWrite_WB  out  1  register-file write enable.
REQ-014 ALU_DATA_WB  out  DATA_W  register-file write data.
REQ-015 RD_WB  out  5  register-file write address.
REQ-016 LOAD_MISALIGN_WB  out  1  misaligned load sits in WB; its write is suppressed.
REQ-017 RETIRED_CNT  out  CNT_W  count of instructions retired through WB.

Function
REQ-018 MEM/WB register capture rules:
- flush=1: capture a bubble (valid=0, RegWrite=0), whatever the value of stall.
- stall=1 and flush=0: hold the register unchanged.
- otherwise: capture all MEM inputs.
REQ-019 Latency: exactly one cycle from MEM inputs to WB outputs; WB outputs are combinational functions of registered state only.
REQ-020 MemtoReg=0: ALU_DATA_WB equals the registered ALU result.
REQ-021 MemtoReg=1: select the byte lane by registered address bits [1:0].
- LB (000) and LH (001): sign-extend.
- LBU (100) and LHU (101): zero-extend.
- LW (010) and funct3 values 011, 110, 111: pass the full word.
REQ-022 Misaligned load conditions (MemtoReg=1 only): LH or LHU with addr[0]=1; word-class funct3 with addr[1:0]≠0.
REQ-023 Misaligned load response: LOAD_MISALIGN_WB=1 and RegWrite_WB=0.
REQ-024 RegWrite_WB = registered RegWrite AND registered valid AND RD≠0 AND NOT misaligned.
REQ-025 RD_WB always presents the registered RD, gated by nothing.
REQ-026 LOAD_MISALIGN_WB=1 only while the offending entry is held; it stays high across stall cycles.
REQ-027 RETIRED_CNT increments by 1 on each edge where the register captures new contents (flush=0, stall=0) with VALID_MEM=1.
REQ-028 RETIRED_CNT counts misaligned loads and x0 writes; it wraps modulo 2^CNT_W with no saturation.
REQ-029 stall=1 with VALID_MEM=1: RETIRED_CNT does not increment.

Reset
REQ-030 rst_n=0 immediately clears all registered state, independent of clk.
REQ-031 Outputs during reset: RegWrite_WB=0, ALU_DATA_WB=0, RD_WB=0, LOAD_MISALIGN_WB=0, RETIRED_CNT=0.
REQ-032 Reset asserted mid-operation discards the in-flight entry; the first capture after rst_n deasserts follows REQ-018.

Structure
REQ-033 Shared package holds the funct3 load encodings (LB, LH, LW, LBU, LHU) and the DATA_W default.
REQ-034 Load-lane extraction and extension live in one combinational sub-module, load_align, which is also reusable for MEM-stage forwarding.
REQ-035 The MEM/WB register, write-enable gating and counter live in wb_stage; no other sub-modules.

Verification
REQ-036 The bench covers these directed scenarios:
- ALU write: RegWrite=1, MemtoReg=0, ALU=0x12345678, RD=5 → next cycle RegWrite_WB=1, ALU_DATA_WB=0x12345678, RD_WB=5, RETIRED_CNT=1.
- LB lane 3: word 0x80FF7F01, addr=...3, LB → 0xFFFFFF80; repeat with LBU → 0x00000080.
- Misaligned LH: LH, addr=...1 → LOAD_MISALIGN_WB=1, RegWrite_WB=0, RETIRED_CNT increments.
- x0 write: RD=0, RegWrite=1 → RegWrite_WB=0, counter increments.
- Stall/flush: stall 3 cycles → outputs frozen, counter unchanged; stall and flush together → bubble, RegWrite_WB=0.
- Reset and wrap: counter preset to 0xFFFFFFFF, one retirement → 0; rst_n low mid-stream → all outputs 0 before the next edge.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg -- shared definitions for the writeback stage.
//   Load funct3 encodings, default datapath width, and the load
//   misalignment rule so the MEM stage can reuse it for forwarding.
package wb_stage_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  // Halfwords must sit on an even address. Everything that is not a byte
  // or halfword load (including the unused 011/110/111 codes) is treated
  // as a word access and must be word aligned.
  function automatic logic load_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
    logic mis;
    case (load_f3_e'(funct3))
      F3_LB, F3_LBU: mis = 1'b0;
      F3_LH, F3_LHU: mis = addr_lo[0];
      default:       mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align -- combinational load lane extraction and extension.
//   word    : raw aligned memory word
//   addr_lo : byte offset within the word
//   funct3  : load size / signedness selector
//   data    : extracted and extended load result
// No state; usable in WB and for MEM-stage forwarding alike.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // A misaligned halfword selects by addr_lo[1] only; its result is never
  // written back, so the odd-offset case needs no special lane.
  assign byte_lane = word[{addr_lo, 3'b000} +: 8];
  assign half_lane = word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    data = word;
    case (load_f3_e'(funct3))
      F3_LB:   data = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      F3_LH:   data = {{(DATA_W-16){half_lane[15]}}, half_lane};
      F3_LBU:  data = {{(DATA_W-8){1'b0}}, byte_lane};
      F3_LHU:  data = {{(DATA_W-16){1'b0}}, half_lane};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage -- MEM/WB pipeline register and writeback logic.
//   Inputs : clk, rst_n, stall, flush, VALID_MEM, RegWrite_MEM,
//            MemtoReg_MEM, ALU_RESULT_MEM, MEM_DATA_MEM, FUNCT3_MEM, RD_MEM
//   Outputs: RegWrite_WB, ALU_DATA_WB, RD_WB, LOAD_MISALIGN_WB, RETIRED_CNT
// WB outputs are combinational functions of the registered entry only.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              VALID_MEM,
  input  logic              RegWrite_MEM,
  input  logic              MemtoReg_MEM,
  input  logic [DATA_W-1:0] ALU_RESULT_MEM,
  input  logic [DATA_W-1:0] MEM_DATA_MEM,
  input  logic [2:0]        FUNCT3_MEM,
  input  logic [4:0]        RD_MEM,
  output logic              RegWrite_WB,
  output logic [DATA_W-1:0] ALU_DATA_WB,
  output logic [4:0]        RD_WB,
  output logic              LOAD_MISALIGN_WB,
  output logic [CNT_W-1:0]  RETIRED_CNT
);

  logic              valid_q;
  logic              reg_write_q;
  logic              mem_to_reg_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic [CNT_W-1:0]  retired_cnt_q;

  logic [DATA_W-1:0] load_data;
  logic              misaligned;

  // Flush wins over stall; a bubble clears the whole entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_q        <= '0;
      mem_data_q   <= '0;
      funct3_q     <= '0;
      rd_q         <= '0;
    end else if (flush) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_q        <= '0;
      mem_data_q   <= '0;
      funct3_q     <= '0;
      rd_q         <= '0;
    end else if (!stall) begin
      valid_q      <= VALID_MEM;
      reg_write_q  <= RegWrite_MEM;
      mem_to_reg_q <= MemtoReg_MEM;
      alu_q        <= ALU_RESULT_MEM;
      mem_data_q   <= MEM_DATA_MEM;
      funct3_q     <= FUNCT3_MEM;
      rd_q         <= RD_MEM;
    end
  end

  // Counts every captured real instruction, including ones whose write
  // is later suppressed (x0 target, misaligned load). Wraps freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt_q <= '0;
    end else if (!flush && !stall && VALID_MEM) begin
      retired_cnt_q <= retired_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .word    (mem_data_q),
    .addr_lo (alu_q[1:0]),
    .funct3  (funct3_q),
    .data    (load_data)
  );

  assign misaligned = valid_q && mem_to_reg_q && load_misaligned(funct3_q, alu_q[1:0]);

  assign RegWrite_WB      = reg_write_q && valid_q && (rd_q != 5'd0) && !misaligned;
  assign ALU_DATA_WB      = mem_to_reg_q ? load_data : alu_q;
  assign RD_WB            = rd_q;
  assign LOAD_MISALIGN_WB = misaligned;
  assign RETIRED_CNT      = retired_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage -- directed self-checking bench for wb_stage.
//   A second instance with a 4-bit counter exercises counter wrap.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        valid_mem;
  logic        reg_write_mem;
  logic        mem_to_reg_mem;
  logic [31:0] alu_mem;
  logic [31:0] mem_data_mem;
  logic [2:0]  funct3_mem;
  logic [4:0]  rd_mem;

  logic        reg_write_wb;
  logic [31:0] data_wb;
  logic [4:0]  rd_wb;
  logic        misalign_wb;
  logic [31:0] cnt;

  logic        reg_write_wb_s;
  logic [31:0] data_wb_s;
  logic [4:0]  rd_wb_s;
  logic        misalign_wb_s;
  logic [3:0]  cnt_s;

  int n_chk;
  int n_bad;

  wb_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .flush            (flush),
    .VALID_MEM        (valid_mem),
    .RegWrite_MEM     (reg_write_mem),
    .MemtoReg_MEM     (mem_to_reg_mem),
    .ALU_RESULT_MEM   (alu_mem),
    .MEM_DATA_MEM     (mem_data_mem),
    .FUNCT3_MEM       (funct3_mem),
    .RD_MEM           (rd_mem),
    .RegWrite_WB      (reg_write_wb),
    .ALU_DATA_WB      (data_wb),
    .RD_WB            (rd_wb),
    .LOAD_MISALIGN_WB (misalign_wb),
    .RETIRED_CNT      (cnt)
  );

  wb_stage #(.CNT_W(4)) dut_small (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .flush            (flush),
    .VALID_MEM        (valid_mem),
    .RegWrite_MEM     (reg_write_mem),
    .MemtoReg_MEM     (mem_to_reg_mem),
    .ALU_RESULT_MEM   (alu_mem),
    .MEM_DATA_MEM     (mem_data_mem),
    .FUNCT3_MEM       (funct3_mem),
    .RD_MEM           (rd_mem),
    .RegWrite_WB      (reg_write_wb_s),
    .ALU_DATA_WB      (data_wb_s),
    .RD_WB            (rd_wb_s),
    .LOAD_MISALIGN_WB (misalign_wb_s),
    .RETIRED_CNT      (cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [2:0] f3, input logic [4:0] rd);
    valid_mem      = v;
    reg_write_mem  = rw;
    mem_to_reg_mem = m2r;
    alu_mem        = alu;
    mem_data_mem   = mem;
    funct3_mem     = f3;
    rd_mem         = rd;
  endtask

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".rw"},  {31'd0, reg_write_wb}, 32'd0);
    check({tag, ".dat"}, data_wb,               32'd0);
    check({tag, ".rd"},  {27'd0, rd_wb},        32'd0);
    check({tag, ".mis"}, {31'd0, misalign_wb},  32'd0);
    check({tag, ".cnt"}, cnt,                   32'd0);
  endtask

  localparam logic [31:0] WORD = 32'h80FF7F01;

  initial begin
    n_chk = 0;
    n_bad = 0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 5'd0);
    rst_n = 1'b0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ALU write
    drive(1'b1, 1'b1, 1'b0, 32'h12345678, 32'hDEADBEEF, 3'b010, 5'd5);
    step();
    check("alu.rw",  {31'd0, reg_write_wb}, 32'd1);
    check("alu.dat", data_wb,               32'h12345678);
    check("alu.rd",  {27'd0, rd_wb},        32'd5);
    check("alu.cnt", cnt,                   32'd1);

    // Load lanes
    drive(1'b1, 1'b1, 1'b1, 32'h00001003, WORD, 3'b000, 5'd6);
    step();
    check("lb3.dat", data_wb, 32'hFFFFFF80);
    check("lb3.rw",  {31'd0, reg_write_wb}, 32'd1);
    check("lb3.cnt", cnt, 32'd2);
    drive(1'b1, 1'b1, 1'b1, 32'h00001003, WORD, 3'b100, 5'd6);
    step();
    check("lbu3.dat", data_wb, 32'h00000080);
    drive(1'b1, 1'b1, 1'b1, 32'h00001002, WORD, 3'b001, 5'd6);
    step();
    check("lh2.dat", data_wb, 32'hFFFF80FF);
    check("lh2.mis", {31'd0, misalign_wb}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h00001002, WORD, 3'b101, 5'd6);
    step();
    check("lhu2.dat", data_wb, 32'h000080FF);
    drive(1'b1, 1'b1, 1'b1, 32'h00001001, WORD, 3'b000, 5'd6);
    step();
    check("lb1.dat", data_wb, 32'h0000007F);
    drive(1'b1, 1'b1, 1'b1, 32'h00001000, WORD, 3'b010, 5'd6);
    step();
    check("lw0.dat", data_wb, WORD);
    check("lw0.cnt", cnt, 32'd7);

    // Misaligned LH, then held across a 3-cycle stall
    drive(1'b1, 1'b1, 1'b1, 32'h00001001, WORD, 3'b001, 5'd6);
    step();
    check("mlh.mis", {31'd0, misalign_wb},  32'd1);
    check("mlh.rw",  {31'd0, reg_write_wb}, 32'd0);
    check("mlh.cnt", cnt, 32'd8);
    stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h00000010, 32'd0, 3'b010, 5'd9);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("mlh_stall%0d.mis", i), {31'd0, misalign_wb},  32'd1);
      check($sformatf("mlh_stall%0d.rw", i),  {31'd0, reg_write_wb}, 32'd0);
      check($sformatf("mlh_stall%0d.cnt", i), cnt, 32'd8);
    end
    stall = 1'b0;

    // Misaligned LW
    drive(1'b1, 1'b1, 1'b1, 32'h00001002, WORD, 3'b010, 5'd6);
    step();
    check("mlw.mis", {31'd0, misalign_wb},  32'd1);
    check("mlw.rw",  {31'd0, reg_write_wb}, 32'd0);
    check("mlw.cnt", cnt, 32'd9);

    // x0 write
    drive(1'b1, 1'b1, 1'b0, 32'h0000ABCD, 32'd0, 3'b000, 5'd0);
    step();
    check("x0.rw",  {31'd0, reg_write_wb}, 32'd0);
    check("x0.mis", {31'd0, misalign_wb},  32'd0);
    check("x0.cnt", cnt, 32'd10);

    // Stall freezes outputs
    drive(1'b1, 1'b1, 1'b0, 32'hA5A5A5A5, 32'd0, 3'b000, 5'd7);
    step();
    check("pre_stall.cnt", cnt, 32'd11);
    stall = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'h00000003, WORD, 3'b000, 5'd12);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d.dat", i), data_wb, 32'hA5A5A5A5);
      check($sformatf("stall%0d.rd", i),  {27'd0, rd_wb}, 32'd7);
      check($sformatf("stall%0d.rw", i),  {31'd0, reg_write_wb}, 32'd1);
      check($sformatf("stall%0d.cnt", i), cnt, 32'd11);
    end

    // Stall and flush together -> bubble, no count
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h11111111, 32'd0, 3'b000, 5'd8);
    step();
    check("flush.rw",  {31'd0, reg_write_wb}, 32'd0);
    check("flush.mis", {31'd0, misalign_wb},  32'd0);
    check("flush.cnt", cnt, 32'd11);
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h22222222, 32'd0, 3'b000, 5'd8);
    step();
    check("invalid.rw",  {31'd0, reg_write_wb}, 32'd0);
    check("invalid.cnt", cnt, 32'd11);

    // Reset mid-stream clears outputs before the next edge
    drive(1'b1, 1'b1, 1'b0, 32'h33333333, 32'd0, 3'b000, 5'd3);
    step();
    check("pre_rst.rw",  {31'd0, reg_write_wb}, 32'd1);
    check("pre_rst.cnt", cnt, 32'd12);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h44444444, 32'd0, 3'b000, 5'd3);
    step();
    check("post_rst.rw",  {31'd0, reg_write_wb}, 32'd1);
    check("post_rst.dat", data_wb, 32'h44444444);
    check("post_rst.cnt", cnt, 32'd1);

    // Counter wrap on the 4-bit instance: preset to all ones, then one more
    rst_n = 1'b0;
    #1;
    check("wrap_rst.cnt", {28'd0, cnt_s}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000, 5'd1);
    for (int i = 0; i < 15; i++) step();
    check("wrap_pre.cnt", {28'd0, cnt_s}, 32'h0000000F);
    step();
    check("wrap.cnt_small", {28'd0, cnt_s}, 32'd0);
    check("wrap.cnt_big",   cnt, 32'd16);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

endmodule
